// File: rtl/lsu_mem_access.sv
// Multi-cycle load/store unit: steers store lanes and strobes, extracts and extends load data,
// and raises misalign / bus_err faults. Holds the core in stall while an access is outstanding.
module lsu_mem_access #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic        mem_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_store,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata,
   output logic [31:0] data_mem,
   output logic        mem_done,
   output logic        stall,
   output logic        misalign,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_we;
   logic [2:0]  r_f3;
   logic [1:0]  r_off;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic [31:0] r_data;
   logic        r_misalign;
   logic        r_bus_err;

   logic        w_fault;
   logic        w_start;
   logic        w_timeout;
   logic        w_to_err;
   logic [8:0]  w_elapsed;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   // alignment and illegal-size check on the incoming request
   always_comb begin
      w_fault = 1'b0;
      case (funct3[1:0])
         2'b00:   w_fault = 1'b0;
         2'b01:   w_fault = data_addr[0];
         2'b10:   w_fault = |data_addr[1:0];
         default: w_fault = 1'b1;
      endcase
      w_fault = w_fault | (mem_we & funct3[2]);
   end

   assign w_start = (r_state == S_IDLE) & mem_en & ~w_fault;

   // store lane replication and strobes; loads carry no strobes
   always_comb begin
      w_wdata = data_store;
      w_wstrb = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            w_wdata = {4{data_store[7:0]}};
            w_wstrb = 4'b0001 << data_addr[1:0];
         end
         2'b01: begin
            w_wdata = {2{data_store[15:0]}};
            w_wstrb = 4'b0011 << data_addr[1:0];
         end
         default: begin
            w_wdata = data_store;
            w_wstrb = 4'b1111;
         end
      endcase
      if (!mem_we) begin
         w_wstrb = 4'b0000;
      end else begin
         w_wstrb = w_wstrb;
      end
   end

   // lane extraction and sign/zero extension of the returned word
   always_comb begin
      w_byte = bus_rdata[{r_off, 3'b000} +: 8];
      w_half = bus_rdata[{r_off[1], 4'b0000} +: 16];
      case (r_f3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'h000000, w_byte};
         3'b101:  w_load = {16'h0000, w_half};
         default: w_load = bus_rdata;
      endcase
   end

   // elapsed counts the IDLE-exit cycle too, so DONE lands TIMEOUT cycles after it
   assign w_elapsed = {1'b0, r_cnt} + 9'd2;
   assign w_timeout = (w_elapsed >= 9'(TIMEOUT));

   // next-state logic
   always_comb begin
      w_next   = r_state;
      w_to_err = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (mem_en) begin
               w_next = w_fault ? S_DONE : S_REQ;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_REQ: begin
            if (w_timeout) begin
               w_next   = S_DONE;
               w_to_err = 1'b1;
            end else if (bus_gnt) begin
               w_next = S_WAIT;
            end else begin
               w_next = S_REQ;
            end
         end
         S_WAIT: begin
            if (bus_rvalid) begin
               w_next = S_DONE;
            end else if (w_timeout) begin
               w_next   = S_DONE;
               w_to_err = 1'b1;
            end else begin
               w_next = S_WAIT;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // request capture, timeout counter, fault flags and load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= 8'd0;
         r_we       <= 1'b0;
         r_f3       <= 3'b000;
         r_off      <= 2'b00;
         r_addr     <= 32'h0000_0000;
         r_wdata    <= 32'h0000_0000;
         r_wstrb    <= 4'b0000;
         r_data     <= 32'h0000_0000;
         r_misalign <= 1'b0;
         r_bus_err  <= 1'b0;
      end else begin
         if (w_start) begin
            r_cnt   <= 8'd0;
            r_we    <= mem_we;
            r_f3    <= funct3;
            r_off   <= data_addr[1:0];
            r_addr  <= {data_addr[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
         end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if ((r_state == S_WAIT) && bus_rvalid && !r_we) begin
            r_data <= w_load;
         end
         r_misalign <= (r_state == S_IDLE) & mem_en & w_fault;
         r_bus_err  <= w_to_err;
      end
   end

   assign bus_req   = (r_state == S_REQ);
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_wstrb = r_wstrb;
   assign data_mem  = r_data;
   assign mem_done  = (r_state == S_DONE);
   assign misalign  = r_misalign;
   assign bus_err   = r_bus_err;
   assign stall     = mem_en & ~rst & (r_state != S_DONE);

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with hand-computed expectations (TIMEOUT = 4).
module tb_lsu_mem_access;

   logic        clk;
   logic        rst;
   logic        mem_en;
   logic        mem_we;
   logic [2:0]  funct3;
   logic [31:0] data_addr;
   logic [31:0] data_store;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;
   logic [31:0] data_mem;
   logic        mem_done;
   logic        stall;
   logic        misalign;
   logic        bus_err;

   int n_total;
   int n_bad;

   // results captured by run_acc
   int          done_cyc;
   int          n_stall;
   logic        seen_req;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;
   logic        cap_we;
   logic        got_mis;
   logic        got_err;
   logic        req_at_done;
   logic        done_after;

   lsu_mem_access #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .funct3(funct3),
      .data_addr(data_addr), .data_store(data_store), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
      .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .data_mem(data_mem), .mem_done(mem_done),
      .stall(stall), .misalign(misalign), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access: gnt whenever bus_req is seen, rvalid the cycle after gnt if give_rv.
   task automatic run_acc(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input logic give_rv);
      logic gnt_prev;
      logic fin;
      gnt_prev   = 1'b0;
      fin        = 1'b0;
      done_cyc   = -1;
      n_stall    = 0;
      seen_req   = 1'b0;
      cap_addr   = 32'h0;
      cap_wdata  = 32'h0;
      cap_wstrb  = 4'h0;
      cap_we     = 1'b0;
      got_mis    = 1'b0;
      got_err    = 1'b0;
      req_at_done = 1'b0;
      mem_en     = 1'b1;
      mem_we     = we;
      funct3     = f3;
      data_addr  = addr;
      data_store = wd;
      bus_rdata  = rd;
      for (int c = 0; c < 12; c++) begin
         if (!fin) begin
            bus_rvalid = gnt_prev & give_rv;
            bus_gnt    = bus_req;
            #1;
            if (stall) n_stall++;
            if (bus_req && !seen_req) begin
               seen_req  = 1'b1;
               cap_addr  = bus_addr;
               cap_wdata = bus_wdata;
               cap_wstrb = bus_wstrb;
               cap_we    = bus_we;
            end
            if (mem_done) begin
               done_cyc    = c;
               got_mis     = misalign;
               got_err     = bus_err;
               req_at_done = bus_req;
               fin         = 1'b1;
               mem_en      = 1'b0;
            end
            gnt_prev = bus_gnt;
            @(posedge clk);
            #1;
         end
      end
      mem_en     = 1'b0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      #1;
      done_after = mem_done;
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      rst        = 1'b1;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      funct3     = 3'b000;
      data_addr  = 32'h0;
      data_store = 32'h0;
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 32'h0;
      tick();
      tick();
      check_val("rst_req",   {31'd0, bus_req},  32'd0);
      check_val("rst_done",  {31'd0, mem_done}, 32'd0);
      check_val("rst_dmem",  data_mem,          32'h0);
      check_val("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
      rst = 1'b0;
      tick();

      // LW minimum latency
      run_acc(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1);
      check_val("lw_addr",   cap_addr, 32'h0000_0100);
      check_val("lw_wstrb",  {28'd0, cap_wstrb}, 32'd0);
      check_val("lw_done",   32'(done_cyc), 32'd3);
      check_val("lw_stall",  32'(n_stall), 32'd3);
      check_val("lw_dmem",   data_mem, 32'hDEAD_BEEF);
      check_val("lw_pulse",  {31'd0, done_after}, 32'd0);

      // sub-word loads
      run_acc(1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1'b1);
      check_val("lb_dmem",   data_mem, 32'hFFFF_FF80);
      check_val("lb_addr",   cap_addr, 32'h0000_0200);
      run_acc(1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1'b1);
      check_val("lbu_dmem",  data_mem, 32'h0000_0080);
      run_acc(1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h80FF_1234, 1'b1);
      check_val("lh_dmem",   data_mem, 32'hFFFF_80FF);
      run_acc(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h80FF_1234, 1'b1);
      check_val("lhu_dmem",  data_mem, 32'h0000_80FF);
      run_acc(1'b0, 3'b000, 32'h0000_0200, 32'h0, 32'h80FF_1274, 1'b1);
      check_val("lb0_dmem",  data_mem, 32'h0000_0074);

      // stores
      run_acc(1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 1'b1);
      check_val("sb_wdata",  cap_wdata, 32'hA5A5_A5A5);
      check_val("sb_wstrb",  {28'd0, cap_wstrb}, 32'h2);
      check_val("sb_we",     {31'd0, cap_we}, 32'd1);
      check_val("sb_addr",   cap_addr, 32'h0000_0300);
      check_val("sb_done",   32'(done_cyc), 32'd3);
      check_val("sb_dmem",   data_mem, 32'h0000_0074);
      run_acc(1'b1, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 32'h0, 1'b1);
      check_val("sh_wdata",  cap_wdata, 32'hBEEF_BEEF);
      check_val("sh_wstrb",  {28'd0, cap_wstrb}, 32'hC);
      run_acc(1'b1, 3'b010, 32'h0000_0304, 32'h1234_5678, 32'h0, 1'b1);
      check_val("sw_wdata",  cap_wdata, 32'h1234_5678);
      check_val("sw_wstrb",  {28'd0, cap_wstrb}, 32'hF);

      // faults: no bus traffic, misalign with mem_done in cycle 1
      run_acc(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h5555_5555, 1'b1);
      check_val("mis_req",   {31'd0, seen_req}, 32'd0);
      check_val("mis_done",  32'(done_cyc), 32'd1);
      check_val("mis_flag",  {31'd0, got_mis}, 32'd1);
      check_val("mis_dmem",  data_mem, 32'h0000_0074);
      run_acc(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h5555_5555, 1'b1);
      check_val("f3_flag",   {31'd0, got_mis}, 32'd1);
      run_acc(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h5555_5555, 1'b1);
      check_val("sbu_flag",  {31'd0, got_mis}, 32'd1);
      check_val("sbu_req",   {31'd0, seen_req}, 32'd0);
      run_acc(1'b0, 3'b001, 32'h0000_0203, 32'h0, 32'h5555_5555, 1'b1);
      check_val("lh_odd",    {31'd0, got_mis}, 32'd1);

      // timeout: gnt but no rvalid
      run_acc(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h7777_7777, 1'b0);
      check_val("to_done",   32'(done_cyc), 32'd4);
      check_val("to_err",    {31'd0, got_err}, 32'd1);
      check_val("to_req",    {31'd0, req_at_done}, 32'd0);
      check_val("to_mis",    {31'd0, got_mis}, 32'd0);
      check_val("to_dmem",   data_mem, 32'h0000_0074);
      bus_rdata  = 32'h1111_1111;
      bus_rvalid = 1'b1;
      tick();
      bus_rvalid = 1'b0;
      #1;
      check_val("late_rv",   data_mem, 32'h0000_0074);
      check_val("late_done", {31'd0, mem_done}, 32'd0);

      // reset while in WAIT, then a fresh access with mem_en held
      mem_en    = 1'b1;
      mem_we    = 1'b0;
      funct3    = 3'b010;
      data_addr = 32'h0000_0500;
      tick();
      bus_gnt = 1'b1;
      tick();
      bus_gnt = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check_val("mrst_req",  {31'd0, bus_req}, 32'd0);
      check_val("mrst_stl",  {31'd0, stall}, 32'd0);
      check_val("mrst_done", {31'd0, mem_done}, 32'd0);
      check_val("mrst_dmem", data_mem, 32'h0);
      bus_rvalid = 1'b1;
      bus_rdata  = 32'h2222_2222;
      tick();
      rst        = 1'b0;
      bus_rvalid = 1'b0;
      run_acc(1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hCAFE_F00D, 1'b1);
      check_val("post_done", 32'(done_cyc), 32'd3);
      check_val("post_dmem", data_mem, 32'hCAFE_F00D);
      check_val("post_err",  {31'd0, got_err}, 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Multi-cycle load/store unit that produces the `data_mem` value consumed by the write-back select stage.
- Sits between execute (effective address, store data, funct3) and a request/response data-memory bus.
- Stalls the core while an access is outstanding.
- Performs byte-lane steering and strobes for stores, and lane extraction plus sign/zero extension for loads.
- Flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, max cycles spent in REQ+WAIT before aborting with bus_err (1..255)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
mem_en  input  1  current instruction is a load/store; held high until mem_done
mem_we  input  1  1 = store, 0 = load; valid while mem_en
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
data_addr  input  32  effective byte address from ALU
data_store  input  32  rs2 value for stores
bus_req  output  1  request valid
bus_we  output  1  request is write
bus_addr  output  32  word address, {data_addr[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte strobes (0000 for loads)
bus_gnt  input  1  request accepted this cycle
bus_rvalid  input  1  response (read data or write ack)
bus_rdata  input  32  read word
data_mem  output  32  extended load result to write-back; held until next access completes
mem_done  output  1  one-cycle pulse, access finished
stall  output  1  freeze PC/pipeline
misalign  output  1  one-cycle pulse with mem_done on alignment or illegal-funct3 fault
bus_err  output  1  one-cycle pulse with mem_done on timeout

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-access drops bus_req asynchronously, and any late rvalid is ignored.
- stall = mem_en & (state != DONE). The value is combinational.
- Fault check in IDLE:
  - H/HU with addr[0]=1 is a fault.
  - W with addr[1:0]!=0 is a fault.
  - funct3[1:0]==11 is a fault.
  - Store with funct3[2]=1 is a fault.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ when mem_en and no fault.
  - IDLE -> DONE when mem_en and fault. On a fault: misalign=1 in DONE, data_mem unchanged, no bus request issued.
  - REQ: bus_req=1; bus_we, bus_addr, bus_wdata and bus_wstrb are driven from registered copies captured on IDLE exit. They are stable until gnt. REQ -> WAIT on bus_gnt.
  - WAIT: bus_req=0. bus_rvalid is sampled only here, earliest the cycle after gnt. rvalid -> DONE; for loads, the extended data is registered into data_mem.
  - DONE: mem_done=1, stall=0. DONE always -> IDLE, giving one idle cycle between accesses.
- Timeout: a counter clears on IDLE exit and increments each cycle in REQ or WAIT. When it reaches TIMEOUT, the FSM goes -> DONE with bus_err=1 and bus_req=0, and data_mem is unchanged.
- Minimum latency: load/store with gnt in the first REQ cycle and rvalid in the next cycle gives mem_done 3 cycles after IDLE exit, i.e. 4 cycles of mem_en.
- Store steering (o = addr[1:0]):
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001<<o.
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011<<o.
  - SW: wdata = d, wstrb = 1111.
- Load extraction: byte = rdata[8*o+:8]; half = rdata[16*o[1]+:16].
  - B/H sign-extend bit 7/15.
  - BU/HU zero-extend.
  - W passes the word through.
- bus_rvalid outside WAIT and bus_gnt outside REQ are ignored.
- mem_en dropping mid-access (only possible under a flush) does not abort: the access completes, the FSM returns to IDLE, and mem_done still pulses.

Test Plan:
- Reset, then LW addr 0x100, gnt on cycle 1, rvalid on cycle 2 with rdata 0xDEADBEEF -> bus_addr 0x100, wstrb 0000, data_mem 0xDEADBEEF, mem_done on cycle 3, stall high for exactly 3 cycles.
- LB addr 0x203, rdata 0x80FF_1234 -> data_mem 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x000080FF.
- SB addr 0x301, data_store 0x000000A5 -> bus_wdata 0xA5A5A5A5, wstrb 0010, bus_we 1; SH addr 0x302 data 0x1234BEEF -> wdata 0xBEEFBEEF, wstrb 1100.
- LW addr 0x102 -> no bus_req at any point, misalign and mem_done pulse together in cycle 1, data_mem keeps its prior value.
- TIMEOUT=4, gnt then no rvalid -> bus_err with mem_done 4 cycles after IDLE exit, bus_req low; a later rvalid while in IDLE leaves data_mem unchanged.
- Assert rst while in WAIT -> bus_req, stall, mem_done all 0 immediately; with mem_en held, a fresh access starts after rst deasserts and completes normally.
